// File: rtl/pc_pkg.sv
// pc_pkg
//   Types and constants shared by the fetch-stage PC unit and its return-address
//   stack (also used by fetch and decode).
//   - next_sel_e : next-PC source (sequential, Result, RAS top)
//   - clog2      : elaboration-time ceil(log2(v)); returns 0 for v <= 1
//   - PC_WIDTH_DEFAULT / PC_STEP_DEFAULT : default address width and fetch step
package pc_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_RESULT = 2'd1,
    SEL_RAS    = 2'd2
  } next_sel_e;

  localparam int PC_WIDTH_DEFAULT = 32;
  localparam int PC_STEP_DEFAULT  = 4;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// ras_stack
//   Circular return-address stack with saturating occupancy count. When full, a
//   push overwrites the oldest entry (the pointer simply wraps) and the count
//   stays at DEPTH.
// Ports
//   i_clk      in   clock, rising edge
//   i_reset    in   synchronous active-high reset (ptr and count cleared)
//   i_push     in   write i_data at ptr, advance ptr
//   i_pop      in   retreat ptr (top entry consumed)
//   i_replace  in   overwrite the top entry in place (ptr/count unchanged)
//   i_data     in   WIDTH  value to push / replace
//   o_top      out  WIDTH  entry at ptr-1 (combinational)
//   o_empty    out  count == 0
//   o_full     out  count == DEPTH
// The caller guarantees push, pop and replace are mutually exclusive.
module ras_stack
  import pc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_replace,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_top_idx;

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  assign w_top_idx = r_ptr - PW'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));

  // Storage has no reset; entries are only read while the count says they are valid.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (i_push) begin
        r_mem[r_ptr] <= i_data;
      end else if (i_replace) begin
        r_mem[w_top_idx] <= i_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_ptr <= r_ptr + PW'(1);
      if (!o_full) begin
        r_count <= r_count + CW'(1);
      end
    end else if (i_pop) begin
      r_ptr   <= r_ptr - PW'(1);
      r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/program_counter_ras.sv
// program_counter_ras
//   Fetch-stage next-PC unit: sequential step, redirect to Result, stall hold,
//   and call/return prediction through a circular return-address stack.
//   Optional feature macro: PC_ALIGN_CHECK_EN (redirect alignment check; when
//   undefined Result is used verbatim and o_misalign is tied 0).
// Ports
//   i_clk        in   clock, rising edge
//   i_reset      in   synchronous active-high reset, wins over everything
//   i_stall      in   hold PC, RAS and Misalign; other controls ignored
//   i_pc_src     in   redirect to i_result
//   i_call       in   push PC+STEP, redirect to i_result
//   i_ret        in   next PC from RAS top (i_result if stack empty)
//   i_result     in   WIDTH  branch/call target
//   o_pc         out  WIDTH  current PC (registered)
//   o_pc_plus_4  out  WIDTH  PC + STEP (combinational, wraps)
//   o_ras_empty  out  stack count == 0
//   o_ras_full   out  stack count == RAS_DEPTH
//   o_ras_miss   out  Ret on empty stack while not stalled (combinational)
//   o_misalign   out  registered redirect alignment fault
module program_counter_ras
  import pc_pkg::*;
#(
  parameter int               WIDTH        = PC_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               STEP         = PC_STEP_DEFAULT,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_pc_src,
  input  logic             i_call,
  input  logic             i_ret,
  input  logic [WIDTH-1:0] i_result,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc_plus_4,
  output logic             o_ras_empty,
  output logic             o_ras_full,
  output logic             o_ras_miss,
  output logic             o_misalign
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_next_pc;
  logic [WIDTH-1:0] w_ras_top;
  logic [WIDTH-1:0] w_result_fix;
  logic             w_ret_hit;
  logic             w_push;
  logic             w_pop;
  logic             w_replace;
  next_sel_e        w_sel;

  assign o_pc        = r_pc;
  assign o_pc_plus_4 = r_pc + WIDTH'(STEP);

  // A return only consumes the stack when there is something on it.
  assign w_ret_hit  = i_ret && !o_ras_empty;
  assign o_ras_miss = i_ret && o_ras_empty && !i_stall;

  // Call+Ret on a non-empty stack: return to the top and replace it with our
  // own return address. Call+Ret on an empty stack behaves as a plain Call.
  assign w_push    = !i_stall && i_call && !w_ret_hit;
  assign w_pop     = !i_stall && w_ret_hit && !i_call;
  assign w_replace = !i_stall && w_ret_hit && i_call;

  always_comb begin
    w_sel = SEL_SEQ;
    if (w_ret_hit) begin
      w_sel = SEL_RAS;
    end else if (i_call || i_pc_src || i_ret) begin
      w_sel = SEL_RESULT;
    end
  end

  always_comb begin
    w_next_pc = o_pc_plus_4;
    case (w_sel)
      SEL_RAS:    w_next_pc = w_ras_top;
      SEL_RESULT: w_next_pc = w_result_fix;
      default:    w_next_pc = o_pc_plus_4;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  // Mask is zero when STEP == 1, which disables the check entirely.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

  logic r_misalign;
  logic w_fault;

  assign w_fault      = (w_sel == SEL_RESULT) && ((i_result & ALIGN_MASK) != '0);
  assign w_result_fix = i_result & ~ALIGN_MASK;
  assign o_misalign   = r_misalign;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_misalign <= 1'b0;
    end else if (!i_stall) begin
      r_misalign <= w_fault;
    end
  end
`else
  assign w_result_fix = i_result;
  assign o_misalign   = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc <= RESET_VECTOR;
    end else if (!i_stall) begin
      r_pc <= w_next_pc;
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (WIDTH)
  ) u_ras (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_replace (w_replace),
    .i_data    (o_pc_plus_4),
    .o_top     (w_ras_top),
    .o_empty   (o_ras_empty),
    .o_full    (o_ras_full)
  );

endmodule

// File: tb/tb_program_counter_ras.sv
module tb_program_counter_ras;

  logic        clk = 1'b0;
  logic        reset, stall, pc_src, call, ret;
  logic [31:0] result;
  logic [31:0] pc, pc4;
  logic        empty, full, miss, misal;

  logic [31:0] rv_pc, rv_pc4;
  logic        rv_empty, rv_full, rv_miss, rv_misal;

  logic        r8_reset, s8_stall, s8_pc_src, s8_call, s8_ret;
  logic [7:0]  s8_result;
  logic [7:0]  w8_pc, w8_pc4;
  logic        w8_empty, w8_full, w8_miss, w8_misal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  program_counter_ras u_dut (
    .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_pc_src(pc_src),
    .i_call(call), .i_ret(ret), .i_result(result),
    .o_pc(pc), .o_pc_plus_4(pc4), .o_ras_empty(empty), .o_ras_full(full),
    .o_ras_miss(miss), .o_misalign(misal)
  );

  program_counter_ras #(.RESET_VECTOR(32'h100)) u_dut_rv (
    .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_pc_src(pc_src),
    .i_call(call), .i_ret(ret), .i_result(result),
    .o_pc(rv_pc), .o_pc_plus_4(rv_pc4), .o_ras_empty(rv_empty), .o_ras_full(rv_full),
    .o_ras_miss(rv_miss), .o_misalign(rv_misal)
  );

  program_counter_ras #(.WIDTH(8), .RESET_VECTOR(8'h00)) u_dut_w8 (
    .i_clk(clk), .i_reset(r8_reset), .i_stall(s8_stall), .i_pc_src(s8_pc_src),
    .i_call(s8_call), .i_ret(s8_ret), .i_result(s8_result),
    .o_pc(w8_pc), .o_pc_plus_4(w8_pc4), .o_ras_empty(w8_empty), .o_ras_full(w8_full),
    .o_ras_miss(w8_miss), .o_misalign(w8_misal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_main();
    stall = 0; pc_src = 0; call = 0; ret = 0; result = 32'h0;
  endtask

  initial begin
    idle_main();
    reset = 1;
    r8_reset = 1; s8_stall = 0; s8_pc_src = 0; s8_call = 0; s8_ret = 0; s8_result = 8'h0;
    step(); step();

    // 1: reset state and sequential stepping
    chk("rst_pc", pc, 32'h0);
    chk("rst_empty", {31'b0, empty}, 32'h1);
    chk("rst_full", {31'b0, full}, 32'h0);
    chk("rst_misalign", {31'b0, misal}, 32'h0);
    chk("rst_rv_pc", rv_pc, 32'h100);
    reset = 0;
    step(); chk("seq_pc1", pc, 32'h4); chk("seq_rv_pc1", rv_pc, 32'h104);
    step(); chk("seq_pc2", pc, 32'h8);
    step(); chk("seq_pc3", pc, 32'hC);
    step(); chk("seq_pc4", pc, 32'h10);
    $display("step 1 reset/sequential pc=0x%0h", pc);

    // 2: call from 0x10 to 0x40, return to 0x14
    call = 1; result = 32'h40; #1;
    chk("call_pc4", pc4, 32'h14);
    chk("call_miss", {31'b0, miss}, 32'h0);
    step(); chk("call_pc", pc, 32'h40); chk("call_nonempty", {31'b0, empty}, 32'h0);
    call = 0; ret = 1; result = 32'h999;
    step(); chk("ret_pc", pc, 32'h14); chk("ret_empty", {31'b0, empty}, 32'h1);
    idle_main();
    $display("step 2 call/ret pc=0x%0h", pc);

    // 3: five calls overflow a 4-deep stack, then drain it
    reset = 1; step(); reset = 0;
    chk("rst2_pc", pc, 32'h0);
    for (int i = 0; i < 5; i++) begin
      call = 1; result = 32'((i + 1) * 4);
      step();
      chk("ovf_call_pc", pc, 32'((i + 1) * 4));
      if (i >= 3) chk("ovf_full", {31'b0, full}, 32'h1);
      else        chk("ovf_notfull", {31'b0, full}, 32'h0);
    end
    call = 0; ret = 1; result = 32'h80;
    for (int k = 0; k < 4; k++) begin
      #1; chk("drain_miss", {31'b0, miss}, 32'h0);
      step();
      chk("drain_pc", pc, 32'(32'h14 - 4 * k));
    end
    chk("drain_empty", {31'b0, empty}, 32'h1);
    chk("drain_notfull", {31'b0, full}, 32'h0);
    #1; chk("underflow_miss", {31'b0, miss}, 32'h1);
    step(); chk("underflow_pc", pc, 32'h80);
    idle_main();
    $display("step 3 overflow/underflow pc=0x%0h", pc);

    // 4: stall holds everything and masks RAS_Miss
    stall = 1; call = 1; pc_src = 1; ret = 1; result = 32'h300; #1;
    chk("stall_miss", {31'b0, miss}, 32'h0);
    step(); chk("stall_pc1", pc, 32'h80);
    step(); chk("stall_pc2", pc, 32'h80);
    chk("stall_empty", {31'b0, empty}, 32'h1);
    chk("stall_full", {31'b0, full}, 32'h0);
    idle_main();
    pc_src = 1; result = 32'h500;
    step(); chk("pcsrc_pc", pc, 32'h500); chk("pcsrc_empty", {31'b0, empty}, 32'h1);
    // Call+Ret on empty stack acts as Call and flags a miss
    pc_src = 0; call = 1; ret = 1; result = 32'h600; #1;
    chk("callret_empty_miss", {31'b0, miss}, 32'h1);
    step(); chk("callret_empty_pc", pc, 32'h600); chk("callret_empty_push", {31'b0, empty}, 32'h0);
    call = 0; ret = 1; result = 32'h0;
    step(); chk("callret_empty_ret", pc, 32'h504);
    idle_main();
    $display("step 4 stall/call-ret-empty pc=0x%0h", pc);

    // 5: 8-bit instance: wrap and same-cycle Call+Ret
    r8_reset = 0;
    s8_pc_src = 1; s8_result = 8'hFC;
    step(); chk("w8_fc", {24'b0, w8_pc}, 32'hFC);
    s8_pc_src = 0;
    #1; chk("w8_pc4_wrap", {24'b0, w8_pc4}, 32'h00);
    step(); chk("w8_wrap", {24'b0, w8_pc}, 32'h00);
    s8_pc_src = 1; s8_result = 8'h1C;
    step(); chk("w8_1c", {24'b0, w8_pc}, 32'h1C);
    s8_pc_src = 0; s8_call = 1; s8_result = 8'h30;
    step(); chk("w8_call", {24'b0, w8_pc}, 32'h30);
    s8_ret = 1; s8_result = 8'h99;
    step(); chk("w8_callret_pc", {24'b0, w8_pc}, 32'h20);
    chk("w8_callret_nonempty", {31'b0, w8_empty}, 32'h0);
    s8_call = 0;
    step(); chk("w8_ret_replaced", {24'b0, w8_pc}, 32'h34);
    chk("w8_count_same", {31'b0, w8_empty}, 32'h1);
    s8_ret = 0;
    $display("step 5 width8 pc=0x%0h", w8_pc);

    // 6: redirect alignment
    pc_src = 1; result = 32'h42;
    step();
`ifdef PC_ALIGN_CHECK_EN
    chk("align_pc", pc, 32'h40);
    chk("align_flag", {31'b0, misal}, 32'h1);
    idle_main();
    step(); chk("align_clear", {31'b0, misal}, 32'h0); chk("align_next_pc", pc, 32'h44);
`else
    chk("align_pc", pc, 32'h42);
    chk("align_flag", {31'b0, misal}, 32'h0);
    idle_main();
    step(); chk("align_clear", {31'b0, misal}, 32'h0); chk("align_next_pc", pc, 32'h46);
`endif
    $display("step 6 alignment pc=0x%0h", pc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
